// File: rtl/doa_peak_search.sv
// -----------------------------------------------------------------------------
// doa_peak_search
// Scans one beam-power sample per steering angle and reports the angle index
// and value of the maximum power once a full scan of NUM_ANGLES samples has
// been accepted. Ties keep the lowest angle index. An in_sof arriving before
// the scan completes aborts it, pulses err_resync and restarts from angle 0.
//
// Optional feature (macro DOA_PEAK_THRESH_EN): adds a threshold input and a
// detect flag registered together with the result.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake (in_ready low while a result waits)
//   in_sof               : sample is angle index 0 of a scan
//   in_power             : unsigned beam power
//   out_valid/out_ready  : result handshake
//   out_angle, out_peak  : index and value of the scan maximum
//   err_resync           : one-cycle pulse when a scan is aborted by in_sof
//   thresh, out_detect   : (DOA_PEAK_THRESH_EN only) out_peak >= thresh
// -----------------------------------------------------------------------------
module doa_peak_search #(
    parameter int unsigned WORD_LENGTH_IN = 80,
    parameter int unsigned NUM_ANGLES     = 181,
    parameter int unsigned ANGLE_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [WORD_LENGTH_IN-1:0] in_power,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ANGLE_WIDTH-1:0]    out_angle,
    output logic [WORD_LENGTH_IN-1:0] out_peak,
    output logic                      err_resync
`ifdef DOA_PEAK_THRESH_EN
    ,
    input  logic [WORD_LENGTH_IN-1:0] thresh,
    output logic                      out_detect
`endif
);

    localparam int unsigned LAST_IDX = NUM_ANGLES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ANGLE_WIDTH-1:0]    cnt_q, cnt_d;
    logic [WORD_LENGTH_IN-1:0] peak_q, peak_d;
    logic [ANGLE_WIDTH-1:0]    angle_q, angle_d;
    logic                      out_valid_q, out_valid_d;
    logic [ANGLE_WIDTH-1:0]    out_angle_q, out_angle_d;
    logic [WORD_LENGTH_IN-1:0] out_peak_q, out_peak_d;
    logic                      err_q, err_d;
    logic                      in_ready_q, in_ready_d;
    logic                      accept;
    logic                      load_out;
`ifdef DOA_PEAK_THRESH_EN
    logic                      detect_q, detect_d;
`endif

    assign accept = in_valid && in_ready_q;

    // Next-state, running peak and result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        peak_d      = peak_q;
        angle_d     = angle_q;
        out_angle_d = out_angle_q;
        out_peak_d  = out_peak_q;
        err_d       = 1'b0;
        load_out    = 1'b0;

        case (state_q)
            IDLE, SCAN: begin
                if (accept && in_sof) begin
                    // Start (or restart) a scan with this sample as angle 0
                    peak_d  = in_power;
                    angle_d = '0;
                    err_d   = (state_q == SCAN);
                    if (NUM_ANGLES == 1) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        load_out = 1'b1;
                    end else begin
                        state_d = SCAN;
                        cnt_d   = ANGLE_WIDTH'(1);
                    end
                end else if (accept && (state_q == SCAN)) begin
                    // Strictly greater keeps the lowest index on ties
                    if (in_power > peak_q) begin
                        peak_d  = in_power;
                        angle_d = cnt_q;
                    end
                    if (cnt_q == ANGLE_WIDTH'(LAST_IDX)) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        load_out = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ANGLE_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_out) begin
            out_peak_d  = peak_d;
            out_angle_d = angle_d;
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d != DONE);
    end

`ifdef DOA_PEAK_THRESH_EN
    // Detect flag captured with the result and held alongside it
    always_comb begin
        detect_d = detect_q;
        if (load_out) begin
            detect_d = (peak_d >= thresh);
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            peak_q      <= '0;
            angle_q     <= '0;
            out_valid_q <= 1'b0;
            out_angle_q <= '0;
            out_peak_q  <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            peak_q      <= peak_d;
            angle_q     <= angle_d;
            out_valid_q <= out_valid_d;
            out_angle_q <= out_angle_d;
            out_peak_q  <= out_peak_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef DOA_PEAK_THRESH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect_d;
        end
    end

    assign out_detect = detect_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_angle  = out_angle_q;
    assign out_peak   = out_peak_q;
    assign err_resync = err_q;

endmodule

// File: tb/tb_doa_peak_search.sv
// -----------------------------------------------------------------------------
// tb_doa_peak_search
// Directed scenarios followed by randomized scans (junk, aborted scans, input
// gaps, output backpressure) checked against a reference peak model.
// -----------------------------------------------------------------------------
module tb_doa_peak_search;

    localparam int unsigned WL = 80;
    localparam int unsigned NA = 5;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [WL-1:0] in_power;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_angle;
    logic [WL-1:0] out_peak;
    logic          err_resync;
`ifdef DOA_PEAK_THRESH_EN
    logic [WL-1:0] thresh;
    logic          out_detect;
`endif

    always #5 clk = ~clk;

    doa_peak_search #(
        .WORD_LENGTH_IN(WL),
        .NUM_ANGLES    (NA),
        .ANGLE_WIDTH   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_power  (in_power),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_peak  (out_peak),
        .err_resync(err_resync)
`ifdef DOA_PEAK_THRESH_EN
        ,
        .thresh    (thresh),
        .out_detect(out_detect)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    logic [AW-1:0] got_angle[$];
    logic [WL-1:0] got_peak[$];
    logic          got_det[$];
    logic [AW-1:0] exp_angle[$];
    logic [WL-1:0] exp_peak[$];
    logic          exp_det[$];

    logic [WL-1:0] pw[NA];

    // Result and resync monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_angle.push_back(out_angle);
                got_peak.push_back(out_peak);
`ifdef DOA_PEAK_THRESH_EN
                got_det.push_back(out_detect);
`else
                got_det.push_back(1'b0);
`endif
            end
            if (err_resync) begin
                err_cnt++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        got_angle.delete();
        got_peak.delete();
        got_det.delete();
    endtask

    // Present one sample and hold it until the DUT takes it
    task automatic push(input logic sof, input logic [WL-1:0] p);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_power = p;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            cycle();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!acc) check("push_timeout", 128'(acc), 128'(1));
    endtask

    task automatic load5(input int unsigned a, input int unsigned b, input int unsigned c,
                         input int unsigned d, input int unsigned e);
        pw[0] = WL'(a);
        pw[1] = WL'(b);
        pw[2] = WL'(c);
        pw[3] = WL'(d);
        pw[4] = WL'(e);
    endtask

    task automatic maybe_gap(input bit en);
        if (en && ($urandom % 4 == 0)) begin
            repeat ($urandom_range(1, 2)) cycle();
        end
    endtask

    task automatic send_scan(input bit gaps);
        for (int i = 0; i < int'(NA); i++) begin
            maybe_gap(gaps);
            push(i == 0, pw[i]);
        end
    endtask

    // Reference: maximum value first, then the first index holding it
    task automatic ref_peak(output logic [AW-1:0] a, output logic [WL-1:0] m);
        m = '0;
        a = '0;
        for (int i = 0; i < int'(NA); i++) begin
            if (pw[i] > m) m = pw[i];
        end
        for (int i = int'(NA) - 1; i >= 0; i--) begin
            if (pw[i] == m) a = AW'(i);
        end
    endtask

    function automatic logic [WL-1:0] rand_power();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        if ($urandom % 2 == 0) return WL'($urandom_range(0, 7));
        return r[WL-1:0];
    endfunction

    initial begin
        int            e0;
        int            exp_err;
        int            k;
        logic [AW-1:0] ra;
        logic [WL-1:0] rm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_power  = '0;
        out_ready = 1'b1;
`ifdef DOA_PEAK_THRESH_EN
        thresh    = WL'(10);
`endif
        repeat (3) cycle();

        // Reset state
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_angle", 128'(out_angle), 128'(0));
        check("rst_out_peak", 128'(out_peak), 128'(0));
        check("rst_err", 128'(err_resync), 128'(0));
`ifdef DOA_PEAK_THRESH_EN
        check("rst_detect", 128'(out_detect), 128'(0));
`endif
        rst = 1'b0;
        cycle();

        // Basic scan: 3,9,4,9,1 -> angle 1, peak 9
        clear_q();
        load5(3, 9, 4, 9, 1);
        send_scan(1'b0);
        check("basic_valid", 128'(out_valid), 128'(1));
        check("basic_angle", 128'(out_angle), 128'(1));
        check("basic_peak", 128'(out_peak), 128'(9));
        check("basic_in_ready", 128'(in_ready), 128'(0));
`ifdef DOA_PEAK_THRESH_EN
        check("basic_detect", 128'(out_detect), 128'(0));
`endif
        cycle();
        check("basic_valid_fall", 128'(out_valid), 128'(0));
        check("basic_in_ready_back", 128'(in_ready), 128'(1));
        check("basic_count", 128'(got_angle.size()), 128'(1));

        // Backpressure: result held for 10 cycles while upstream pushes
        clear_q();
        out_ready = 1'b0;
        load5(1, 2, 7, 3, 0);
        send_scan(1'b0);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_power = '1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_hold", 128'({out_valid, in_ready, out_angle, out_peak}),
                  128'({1'b1, 1'b0, AW'(2), WL'(7)}));
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("bp_valid_fall", 128'(out_valid), 128'(0));
        check("bp_in_ready", 128'(in_ready), 128'(1));
        cycle();
        check("bp_count", 128'(got_angle.size()), 128'(1));
        if (got_angle.size() == 1) begin
            check("bp_angle", 128'(got_angle[0]), 128'(2));
            check("bp_peak", 128'(got_peak[0]), 128'(7));
        end

        // Resync: sof + 2 samples, then a full scan peaking at index 4
        clear_q();
        e0 = err_cnt;
        push(1'b1, WL'(5));
        push(1'b0, WL'(6));
        push(1'b0, WL'(7));
        load5(1, 2, 3, 4, 50);
        push(1'b1, pw[0]);
        check("resync_pulse", 128'(err_resync), 128'(1));
        for (int i = 1; i < int'(NA); i++) push(1'b0, pw[i]);
        check("resync_pulse_gone", 128'(err_resync), 128'(0));
        repeat (2) cycle();
        check("resync_err_count", 128'(err_cnt - e0), 128'(1));
        check("resync_count", 128'(got_angle.size()), 128'(1));
        if (got_angle.size() == 1) begin
            check("resync_angle", 128'(got_angle[0]), 128'(4));
            check("resync_peak", 128'(got_peak[0]), 128'(50));
        end

        // Junk before sof is ignored
        clear_q();
        push(1'b0, WL'(100));
        push(1'b0, WL'(200));
        push(1'b0, WL'(300));
        load5(2, 8, 8, 1, 5);
        send_scan(1'b0);
        cycle();
        check("junk_count", 128'(got_angle.size()), 128'(1));
        if (got_angle.size() == 1) begin
            check("junk_angle", 128'(got_angle[0]), 128'(1));
            check("junk_peak", 128'(got_peak[0]), 128'(8));
        end

        // Mid-scan reset discards the partial scan and clears outputs
        push(1'b1, WL'(4));
        push(1'b0, WL'(6));
        rst = 1'b1;
        cycle();
        check("mrst_outputs", 128'({in_ready, out_valid, err_resync, out_angle, out_peak}),
              128'({1'b1, 1'b0, 1'b0, AW'(0), WL'(0)}));
        rst = 1'b0;
        clear_q();
        load5(3, 3, 3, 3, 3);
        send_scan(1'b0);
        cycle();
        check("mrst_count", 128'(got_angle.size()), 128'(1));
        if (got_angle.size() == 1) begin
            check("mrst_angle", 128'(got_angle[0]), 128'(0));
            check("mrst_peak", 128'(got_peak[0]), 128'(3));
        end

`ifdef DOA_PEAK_THRESH_EN
        // Peak equal to threshold detects
        load5(0, 0, 10, 0, 0);
        send_scan(1'b0);
        check("thr_detect", 128'(out_detect), 128'(1));
        check("thr_angle", 128'(out_angle), 128'(2));
        cycle();
`endif

        // Randomized scans with junk, aborts, gaps and backpressure
        clear_q();
        exp_angle.delete();
        exp_peak.delete();
        exp_det.delete();
        e0      = err_cnt;
        exp_err = 0;
        for (int s = 0; s < 40; s++) begin
            repeat ($urandom % 3) push(1'b0, rand_power());
            if ($urandom % 3 == 0) begin
                k = int'($urandom_range(1, 4));
                push(1'b1, rand_power());
                for (int j = 1; j < k; j++) begin
                    maybe_gap(1'b1);
                    push(1'b0, rand_power());
                end
                exp_err++;
            end
            for (int i = 0; i < int'(NA); i++) pw[i] = rand_power();
            send_scan(1'b1);
            ref_peak(ra, rm);
            exp_angle.push_back(ra);
            exp_peak.push_back(rm);
            exp_det.push_back(rm >= WL'(10));
            for (int t = 0; t < 200; t++) begin
                out_ready = 1'($urandom % 2);
                in_valid  = 1'($urandom % 2);
                in_sof    = 1'($urandom % 2);
                in_power  = rand_power();
                cycle();
                if (!out_valid) break;
            end
            in_valid  = 1'b0;
            in_sof    = 1'b0;
            out_ready = 1'b1;
            check("rand_drain", 128'(out_valid), 128'(0));
        end
        cycle();
        check("rand_count", 128'(got_angle.size()), 128'(exp_angle.size()));
        check("rand_err_count", 128'(err_cnt - e0), 128'(exp_err));
        for (int i = 0; i < exp_angle.size() && i < got_angle.size(); i++) begin
            check("rand_angle", 128'(got_angle[i]), 128'(exp_angle[i]));
            check("rand_peak", 128'(got_peak[i]), 128'(exp_peak[i]));
`ifdef DOA_PEAK_THRESH_EN
            check("rand_detect", 128'(got_det[i]), 128'(exp_det[i]));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
